dec_onehot_scan: RTL and testbench
==================================

Name: dec_onehot_scan

Overview:
- Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder; successor to the fixed 3-to-8 combinational decoder.
- Generates register-file write-enables in the processor, with output 0 optionally masked as a hard-wired zero register.
- Adds a scan mode: a single request sweeps every output in turn, one per cycle, for register-file clear, row scanning or test sweeps.
- Reports busy and done status for that sweep.

Parameters:
- SEL_W, 3, select width; OUT_W = 2**SEL_W outputs (derived localparam, not overridable).
- MASK_ZERO, 0, when 1, out[0] never asserts in any mode.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  direct-decode enable
- sel  in  SEL_W  direct-decode select
- scan_start  in  1  request a full sweep; sampled only in IDLE
- out  out  OUT_W  registered one-hot (or all-zero) output
- out_idx  out  SEL_W  registered index of the current decode/sweep position
- busy  out  1  high while in SCAN
- done  out  1  one-cycle pulse after the last sweep position

Behaviour:
- Reset values:
  - Outputs: out=0, out_idx=0, busy=0, done=0.
  - Internal state: state=IDLE, scan counter=0.
- Reset mid-scan aborts the sweep. No done pulse is produced.
- FSM states: IDLE, SCAN, DONE (2-bit state register).
- IDLE, scan_start=0:
  - Next cycle: out = en ? (1<<sel) : 0.
  - out_idx = sel whenever en=1; out_idx holds its value when en=0.
  - Latency is exactly 1 cycle.
- IDLE, scan_start=1:
  - Takes priority over en; sel and en are ignored that cycle.
  - Next cycle: state=SCAN, counter=0, out=1<<0, out_idx=0, busy=1.
- SCAN:
  - Each cycle, counter increments by 1; out=1<<counter and out_idx=counter (registered).
  - en, sel and scan_start are ignored.
  - When the registered counter equals OUT_W-1, the next state is DONE.
  - A sweep holds each output for exactly 1 cycle, giving OUT_W cycles with busy=1.
- DONE:
  - Lasts exactly one cycle: out=0, busy=0, done=1, out_idx=0.
  - Returns to IDLE unconditionally; scan_start is ignored in DONE.
- A new sweep may be requested on the first IDLE cycle after DONE.
- MASK_ZERO=1:
  - Any position 0 drives out=0 (direct mode sel=0, or scan position 0).
  - out_idx still reports 0 and the scan still spends 1 cycle at position 0, so sweep length is unchanged.
- Invariant: out is either zero or exactly one-hot in every cycle.
- Width rules:
  - Counter is SEL_W bits. Overflow cannot occur because the terminal compare precedes wrap.
  - Shift results are sized to OUT_W.

Optional Feature:
- Macro: DEC_SCAN_REV_EN.
- Defined:
  - Adds input port scan_dir (1 bit), sampled with scan_start in IDLE and held in a register for the whole sweep.
  - scan_dir=1: counter loads OUT_W-1, decrements each cycle, and terminates at 0 into DONE.
  - With MASK_ZERO=1, the final reverse position drives out=0.
  - scan_dir=0: identical to the undefined build.
- Undefined: no scan_dir port; ascending sweeps only.

Test Plan (SEL_W=3 unless noted):
- Reset: assert reset 2 cycles with en=1, sel=5 -> out=8'h00, busy=0, done=0, out_idx=0 throughout and on the first cycle after release.
- Direct decode: en=1, sel=0..7 on consecutive cycles -> one cycle later out=01,02,04,...,80 and out_idx tracks sel; then en=0 -> out=00 next cycle.
- Scan: 1-cycle scan_start with en=1, sel=3 ->
  - busy=1 for 8 cycles with out=01,02,...,80;
  - then 1 cycle of done=1, out=00;
  - then IDLE honours en/sel;
  - a scan_start asserted mid-sweep is ignored.
- MASK_ZERO=1: direct sel=0, en=1 -> out=00, out_idx=0; scan -> out=00,02,04,...,80, still 8 busy cycles.
- Reset mid-scan: reset at sweep position 4 -> next cycle out=00, busy=0, no done pulse; a subsequent scan_start restarts at position 0.
- DEC_SCAN_REV_EN defined, scan_dir=1 -> out=80,40,...,01 over 8 cycles, then done; scan_dir=0 -> ascending as above.

Source files
------------

// File: rtl/dec_onehot_scan.sv
// dec_onehot_scan: registered SEL_W-to-2**SEL_W one-hot decoder with a
// self-timed scan sweep that visits every output position once.
// Direct mode decodes sel when en is high. A scan_start request in IDLE
// sweeps positions 0..OUT_W-1, one per cycle, and then pulses done.
// MASK_ZERO=1 keeps out[0] low in every mode, so register 0 reads as zero.
// Optional build macro DEC_SCAN_REV_EN adds a scan_dir input. When
// scan_dir is 1 at the start request, the sweep runs from OUT_W-1 down to 0.
module dec_onehot_scan #(
    parameter int SEL_W     = 3,
    parameter int MASK_ZERO = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  scan_start,
`ifdef DEC_SCAN_REV_EN
    input  logic                  scan_dir,
`endif
    output logic [2**SEL_W-1:0]   out,
    output logic [SEL_W-1:0]      out_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W = 2**SEL_W;

    localparam logic [SEL_W-1:0] POS_FIRST = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] POS_LAST  = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0] POS_STEP  = SEL_W'(1);
    localparam logic [OUT_W-1:0] OUT_ZERO  = {OUT_W{1'b0}};
    localparam logic [OUT_W-1:0] OUT_ONE   = {{(OUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SCAN = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [SEL_W-1:0] cnt_r;
    logic             dir_r;
    logic [OUT_W-1:0] out_r;
    logic [SEL_W-1:0] idx_r;
    logic             busy_r;
    logic             done_r;

    logic             start_dir_s;
    logic [SEL_W-1:0] start_pos_s;
    logic [SEL_W-1:0] next_pos_s;
    logic [SEL_W-1:0] term_pos_s;

    // One-hot decode of a position. Position 0 yields all-zero when it is masked.
    function automatic logic [OUT_W-1:0] decode_f(input logic [SEL_W-1:0] pos);
        logic [OUT_W-1:0] vec;
        if ((MASK_ZERO != 0) && (pos == POS_FIRST)) begin
            vec = OUT_ZERO;
        end else begin
            vec = OUT_ONE << pos;
        end
        return vec;
    endfunction

    // Sweep direction selection: start point, step and terminal position.
    always_comb begin
`ifdef DEC_SCAN_REV_EN
        start_dir_s = scan_dir;
`else
        start_dir_s = 1'b0;
`endif
        if (start_dir_s) begin
            start_pos_s = POS_LAST;
        end else begin
            start_pos_s = POS_FIRST;
        end
        if (dir_r) begin
            next_pos_s = cnt_r - POS_STEP;
            term_pos_s = POS_FIRST;
        end else begin
            next_pos_s = cnt_r + POS_STEP;
            term_pos_s = POS_LAST;
        end
    end

    // Control FSM with registered decode and status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= POS_FIRST;
            dir_r   <= 1'b0;
            out_r   <= OUT_ZERO;
            idx_r   <= POS_FIRST;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (scan_start) begin
                        // A sweep request overrides direct decode for this cycle.
                        state_r <= ST_SCAN;
                        cnt_r   <= start_pos_s;
                        dir_r   <= start_dir_s;
                        out_r   <= decode_f(start_pos_s);
                        idx_r   <= start_pos_s;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                        if (en) begin
                            out_r <= decode_f(sel);
                            idx_r <= sel;
                        end else begin
                            out_r <= OUT_ZERO;
                        end
                    end
                end
                ST_SCAN: begin
                    if (cnt_r == term_pos_s) begin
                        // Terminal compare happens before the counter can wrap.
                        state_r <= ST_DONE;
                        cnt_r   <= POS_FIRST;
                        out_r   <= OUT_ZERO;
                        idx_r   <= POS_FIRST;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= next_pos_s;
                        out_r <= decode_f(next_pos_s);
                        idx_r <= next_pos_s;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    out_r   <= OUT_ZERO;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= POS_FIRST;
                    dir_r   <= 1'b0;
                    out_r   <= OUT_ZERO;
                    idx_r   <= POS_FIRST;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign out     = out_r;
    assign out_idx = idx_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_dec_onehot_scan.sv
// Scoreboard bench for dec_onehot_scan: an unmasked and a MASK_ZERO=1
// instance share all inputs. Stimulus pushes hand-computed expectations.
// A monitor pops one expectation after every rising edge and compares.
module tb_dec_onehot_scan;

    logic       clock;
    logic       reset;
    logic       en;
    logic [2:0] sel;
    logic       scan_start;
    logic       scan_dir;

    logic [7:0] out_a;
    logic [2:0] idx_a;
    logic       busy_a;
    logic       done_a;
    logic [7:0] out_m;
    logic [2:0] idx_m;
    logic       busy_m;
    logic       done_m;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic       chk_out;
        logic [7:0] oa;
        logic [7:0] om;
        logic [2:0] idx;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    dec_onehot_scan #(.SEL_W(3), .MASK_ZERO(0)) dut_a (
        .clock(clock), .reset(reset), .en(en), .sel(sel), .scan_start(scan_start),
`ifdef DEC_SCAN_REV_EN
        .scan_dir(scan_dir),
`endif
        .out(out_a), .out_idx(idx_a), .busy(busy_a), .done(done_a)
    );

    dec_onehot_scan #(.SEL_W(3), .MASK_ZERO(1)) dut_m (
        .clock(clock), .reset(reset), .en(en), .sel(sel), .scan_start(scan_start),
`ifdef DEC_SCAN_REV_EN
        .scan_dir(scan_dir),
`endif
        .out(out_m), .out_idx(idx_m), .busy(busy_m), .done(done_m)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hand-written one-hot table.
    function automatic logic [7:0] oh(input int i);
        case (i)
            0: return 8'h01;
            1: return 8'h02;
            2: return 8'h04;
            3: return 8'h08;
            4: return 8'h10;
            5: return 8'h20;
            6: return 8'h40;
            7: return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] ohm(input int i);
        if (i == 0) return 8'h00;
        else return oh(i);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue the output expected after the next edge.
    task automatic step(input logic rst, input logic e, input logic [2:0] s,
                        input logic ss, input logic sd, input logic chk_out,
                        input logic [7:0] oa, input logic [7:0] om,
                        input logic [2:0] idx, input logic b, input logic d);
        exp_t x;
        @(negedge clock);
        reset      = rst;
        en         = e;
        sel        = s;
        scan_start = ss;
        scan_dir   = sd;
        x.chk_out = chk_out;
        x.oa = oa; x.om = om; x.idx = idx; x.busy = b; x.done = d;
        exp_q.push_back(x);
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation.
    initial begin
        exp_t cur;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                if (cur.chk_out) begin
                    check("out", out_a, cur.oa);
                    check("out_mask", out_m, cur.om);
                    check("out_idx", {5'b00000, idx_a}, {5'b00000, cur.idx});
                    check("out_idx_mask", {5'b00000, idx_m}, {5'b00000, cur.idx});
                end
                check("busy", {7'b0000000, busy_a}, {7'b0000000, cur.busy});
                check("done", {7'b0000000, done_a}, {7'b0000000, cur.done});
                check("busy_mask", {7'b0000000, busy_m}, {7'b0000000, cur.busy});
                check("done_mask", {7'b0000000, done_m}, {7'b0000000, cur.done});
            end
        end
    end

    // Watchdog against a stalled run.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", exp_q.size());
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; en = 1'b1; sel = 3'd5; scan_start = 1'b0; scan_dir = 1'b0;

        // Reset held two cycles with en=1, sel=5.
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b0, 1'b0);

        // Direct decode of sel = 0..7, then en=0 clears out and idx holds.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 3'(i), 1'b0, 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd6, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd7, 1'b0, 1'b0);

        // Ascending sweep requested with en=1, sel=3. The start at position 3 is ignored.
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b1, 3'd3, (i == 3), 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        // This is the DONE cycle. scan_start is ignored and the done pulse ends.
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // Back in IDLE: en/sel are honoured.
        step(1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 8'h08, 8'h08, 3'd3, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b0, 1'b0);

        // Reset at sweep position 4 aborts the sweep without a done pulse.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 5; i++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

        // A new sweep restarts at position 0 and runs to completion.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // A new sweep is accepted on the first IDLE cycle after DONE.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);

`ifdef DEC_SCAN_REV_EN
        // Descending sweep: 80, 40, ..., 01. The last position is masked on the MASK_ZERO instance.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 3'd7, 1'b1, 1'b0);
        for (int i = 6; i >= 0; i--)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        // scan_dir=0 afterwards gives an ascending sweep again.
        step(1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 8'h01, 8'h00, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++)
            step(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, oh(i), ohm(i), 3'(i), 1'b1, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
`endif

        @(negedge clock);
        @(negedge clock);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
